// File: rtl/lock_pkg.sv
// Shared key codes, dialogue states and sizing for the keypad front end of the six-digit lock.
package lock_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int DIGIT_W    = 4;
    localparam int CODE_W     = NUM_DIGITS * DIGIT_W;
    localparam int CNT_W      = 3;

    localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(NUM_DIGITS);

    localparam logic [DIGIT_W-1:0] KEY_MAX_DIGIT = 4'h9;
    localparam logic [DIGIT_W-1:0] KEY_CLEAR     = 4'hA;
    localparam logic [DIGIT_W-1:0] KEY_BKSP      = 4'hB;
    localparam logic [DIGIT_W-1:0] KEY_ENTER     = 4'hC;
    localparam logic [DIGIT_W-1:0] KEY_CHANGE    = 4'hD;

    localparam logic [1:0] MODE_IDLE    = 2'b00;
    localparam logic [1:0] MODE_NEW     = 2'b01;
    localparam logic [1:0] MODE_CONFIRM = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = MODE_IDLE,
        ST_NEW1 = MODE_NEW,
        ST_NEW2 = MODE_CONFIRM
    } state_t;

endpackage

// File: rtl/code_entry_ctrl_digit_buffer.sv
// Six-slot digit buffer: push appends at the current count, pop zeroes the last digit.
// clr wins over pop; clr together with push restarts the buffer holding just the new digit.
module digit_buffer
    import lock_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [DIGIT_W-1:0] push_digit,
    input  logic               pop,
    input  logic               clr,
    output logic [CODE_W-1:0]  digits,
    output logic [CNT_W-1:0]   count,
    output logic               full
);

    logic [DIGIT_W-1:0] dig_q [NUM_DIGITS];
    logic [DIGIT_W-1:0] dig_d [NUM_DIGITS];
    logic [CNT_W-1:0]   count_q, count_d;

    assign full  = (count_q == MAX_COUNT);
    assign count = count_q;

    always_comb begin
        dig_d   = dig_q;
        count_d = count_q;
        if (clr) begin
            for (int i = 0; i < NUM_DIGITS; i++) dig_d[i] = '0;
            count_d = '0;
            if (push) begin
                dig_d[0] = push_digit;
                count_d  = CNT_W'(1);
            end
        end else if (push && !full) begin
            dig_d[count_q] = push_digit;
            count_d        = count_q + CNT_W'(1);
        end else if (pop && count_q != '0) begin
            dig_d[count_q - CNT_W'(1)] = '0;
            count_d                    = count_q - CNT_W'(1);
        end
    end

    // Slot 0 is the first digit typed and lands in the most significant nibble.
    always_comb begin
        digits = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            digits[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = dig_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) dig_q[i] <= '0;
            count_q <= '0;
        end else begin
            dig_q   <= dig_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/code_entry_ctrl.sv
// Keypad entry controller: collects digits, issues compare requests and runs the change-code dialogue.
// All outputs registered; a key sampled at one edge shows its effect after the next edge.
module code_entry_ctrl
    import lock_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_code,
    input  logic               unlocked,
    output logic [CODE_W-1:0]  entry_digits,
    output logic [CNT_W-1:0]   entry_count,
    output logic               cmp_req,
    output logic               pw_we,
    output logic [CODE_W-1:0]  pw_data,
    output logic               err,
    output logic [1:0]         mode
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CODE_W-1:0]  temp_q, temp_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               pend_clr_q, pend_clr_d;
    logic               cmp_q, cmp_d;
    logic               we_q, we_d;
    logic [CODE_W-1:0]  pwd_q, pwd_d;
    logic               err_q, err_d;

    logic               buf_push, buf_pop, buf_clr, buf_full;
    logic [CODE_W-1:0]  buf_digits;
    logic [CNT_W-1:0]   buf_count;
    logic               eff_full, eff_empty, active;

    digit_buffer u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (buf_push),
        .push_digit (key_code),
        .pop        (buf_pop),
        .clr        (buf_clr),
        .digits     (buf_digits),
        .count      (buf_count),
        .full       (buf_full)
    );

    // The buffer stays visible during the cmp_req cycle; a key landing then sees it already emptied.
    assign eff_full  = buf_full && !pend_clr_q;
    assign eff_empty = (buf_count == '0) || pend_clr_q;
    assign active    = (state_q != ST_IDLE) || (buf_count != '0);

    always_comb begin
        state_d    = state_q;
        temp_d     = temp_q;
        timer_d    = timer_q;
        pend_clr_d = 1'b0;
        cmp_d      = 1'b0;
        we_d       = 1'b0;
        pwd_d      = '0;
        err_d      = 1'b0;
        buf_push   = 1'b0;
        buf_pop    = 1'b0;
        buf_clr    = pend_clr_q;

        if (key_valid) begin
            timer_d = '0;
            if (key_code <= KEY_MAX_DIGIT) begin
                buf_push = !eff_full;
            end else begin
                case (key_code)
                    KEY_CLEAR: buf_clr = 1'b1;
                    KEY_BKSP:  buf_pop = !eff_empty;
                    KEY_ENTER: begin
                        buf_clr = 1'b1;
                        if (!eff_full) begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                            temp_d  = '0;
                        end else begin
                            case (state_q)
                                ST_IDLE: begin
                                    buf_clr    = 1'b0;
                                    cmp_d      = 1'b1;
                                    pend_clr_d = 1'b1;
                                end
                                ST_NEW1: begin
                                    temp_d  = buf_digits;
                                    state_d = ST_NEW2;
                                end
                                default: begin
                                    if (buf_digits == temp_q) begin
                                        we_d  = 1'b1;
                                        pwd_d = buf_digits;
                                    end else begin
                                        err_d = 1'b1;
                                    end
                                    temp_d  = '0;
                                    state_d = ST_IDLE;
                                end
                            endcase
                        end
                    end
                    KEY_CHANGE: begin
                        if (state_q == ST_IDLE) begin
                            if (unlocked) begin
                                buf_clr = 1'b1;
                                state_d = ST_NEW1;
                            end
                        end else begin
                            buf_clr = 1'b1;
                            temp_d  = '0;
                            state_d = ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (active) begin
            if (timer_q == TIMER_LAST) begin
                err_d   = 1'b1;
                buf_clr = 1'b1;
                temp_d  = '0;
                state_d = ST_IDLE;
                timer_d = '0;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end else begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            temp_q     <= '0;
            timer_q    <= '0;
            pend_clr_q <= 1'b0;
            cmp_q      <= 1'b0;
            we_q       <= 1'b0;
            pwd_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            temp_q     <= temp_d;
            timer_q    <= timer_d;
            pend_clr_q <= pend_clr_d;
            cmp_q      <= cmp_d;
            we_q       <= we_d;
            pwd_q      <= pwd_d;
            err_q      <= err_d;
        end
    end

    assign entry_digits = buf_digits;
    assign entry_count  = buf_count;
    assign cmp_req      = cmp_q;
    assign pw_we        = we_q;
    assign pw_data      = pwd_q;
    assign err          = err_q;
    assign mode         = state_q;

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Directed bench for code_entry_ctrl; expected outputs queued per step and checked after the edge.
module tb_code_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        unlocked = 1'b0;
    logic [23:0] entry_digits;
    logic [2:0]  entry_count;
    logic        cmp_req, pw_we, err;
    logic [23:0] pw_data;
    logic [1:0]  mode;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [23:0] digits;
        logic [2:0]  count;
        logic [1:0]  mode;
        logic        cmp;
        logic        we;
        logic [23:0] pwd;
        logic        err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    code_entry_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .unlocked     (unlocked),
        .entry_digits (entry_digits),
        .entry_count  (entry_count),
        .cmp_req      (cmp_req),
        .pw_we        (pw_we),
        .pw_data      (pw_data),
        .err          (err),
        .mode         (mode)
    );

    function automatic exp_t mk(input logic [23:0] d, input logic [2:0] c, input logic [1:0] m,
                                input logic cq, input logic we, input logic [23:0] pd, input logic er);
        exp_t e;
        e.digits = d; e.count = c; e.mode = m; e.cmp = cq; e.we = we; e.pwd = pd; e.err = er;
        return e;
    endfunction

    task automatic chk(input string tag, input string fld, input logic [23:0] obs, input logic [23:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, then compare after the edge.
    task automatic step(input logic r, input logic kv, input logic [3:0] kc, input exp_t e, input string tag);
        exp_t x;
        @(negedge clk);
        rst = r; key_valid = kv; key_code = kc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0; key_valid = 1'b0;
        x = sb.pop_front();
        chk(tag, "digits", entry_digits, x.digits);
        chk(tag, "count",  {21'd0, entry_count}, {21'd0, x.count});
        chk(tag, "mode",   {22'd0, mode}, {22'd0, x.mode});
        chk(tag, "cmp",    {23'd0, cmp_req}, {23'd0, x.cmp});
        chk(tag, "we",     {23'd0, pw_we}, {23'd0, x.we});
        chk(tag, "pwdata", pw_data, x.pwd);
        chk(tag, "err",    {23'd0, err}, {23'd0, x.err});
    endtask

    task automatic key(input logic [3:0] kc, input exp_t e, input string tag);
        step(1'b0, 1'b1, kc, e, tag);
    endtask

    task automatic idle(input exp_t e, input string tag);
        step(1'b0, 1'b0, 4'h0, e, tag);
    endtask

    // Type all six nibbles of code; the buffer should show the typed prefix left-aligned.
    task automatic type_code(input logic [23:0] code, input logic [1:0] md, input string tag);
        logic [23:0] m;
        for (int k = 0; k < 6; k++) begin
            m = 24'hFFFFFF;
            m = m << (4 * (5 - k));
            key(code[23-4*k -: 4], mk(code & m, 3'(k + 1), md, 0, 0, 0, 0), tag);
        end
    endtask

    initial begin
        step(1'b1, 1'b0, 4'h0, mk(0, 0, 2'b00, 0, 0, 0, 0), "reset");
        idle(mk(0, 0, 2'b00, 0, 0, 0, 0), "after_reset");

        // Plain unlock entry
        type_code(24'h123456, 2'b00, "unlock_digits");
        key(4'hC, mk(24'h123456, 6, 2'b00, 1, 0, 0, 0), "unlock_enter");
        idle(mk(0, 0, 2'b00, 0, 0, 0, 0), "unlock_clear");
        idle(mk(0, 0, 2'b00, 0, 0, 0, 0), "unlock_quiet");

        // Short entry with backspace, then enter rejected
        key(4'h1, mk(24'h100000, 1, 2'b00, 0, 0, 0, 0), "bk_1");
        key(4'h2, mk(24'h120000, 2, 2'b00, 0, 0, 0, 0), "bk_2");
        key(4'h3, mk(24'h123000, 3, 2'b00, 0, 0, 0, 0), "bk_3");
        key(4'hB, mk(24'h120000, 2, 2'b00, 0, 0, 0, 0), "bk_bksp");
        key(4'h9, mk(24'h129000, 3, 2'b00, 0, 0, 0, 0), "bk_9");
        key(4'hC, mk(0, 0, 2'b00, 0, 0, 0, 1), "short_enter");
        idle(mk(0, 0, 2'b00, 0, 0, 0, 0), "short_after");
        key(4'hB, mk(0, 0, 2'b00, 0, 0, 0, 0), "bksp_empty");
        key(4'hE, mk(0, 0, 2'b00, 0, 0, 0, 0), "ignored_E");

        // Overflow digit ignored, then clear
        type_code(24'h123456, 2'b00, "ovf_digits");
        key(4'h7, mk(24'h123456, 6, 2'b00, 0, 0, 0, 0), "ovf_extra");
        key(4'hA, mk(0, 0, 2'b00, 0, 0, 0, 0), "clear");

        // Successful change dialogue
        unlocked = 1'b1;
        key(4'hD, mk(0, 0, 2'b01, 0, 0, 0, 0), "chg_start");
        type_code(24'h654321, 2'b01, "chg_new");
        key(4'hC, mk(0, 0, 2'b10, 0, 0, 0, 0), "chg_enter1");
        type_code(24'h654321, 2'b10, "chg_confirm");
        key(4'hC, mk(0, 0, 2'b00, 0, 1, 24'h654321, 0), "chg_write");
        idle(mk(0, 0, 2'b00, 0, 0, 0, 0), "chg_after");

        // Confirm mismatch
        key(4'hD, mk(0, 0, 2'b01, 0, 0, 0, 0), "mm_start");
        type_code(24'h111111, 2'b01, "mm_new");
        key(4'hC, mk(0, 0, 2'b10, 0, 0, 0, 0), "mm_enter1");
        type_code(24'h111112, 2'b10, "mm_confirm");
        key(4'hC, mk(0, 0, 2'b00, 0, 0, 0, 1), "mm_err");

        // Change refused while locked
        unlocked = 1'b0;
        key(4'hD, mk(0, 0, 2'b00, 0, 0, 0, 0), "chg_locked");

        // Timeout discards a partial entry
        key(4'h1, mk(24'h100000, 1, 2'b00, 0, 0, 0, 0), "to_1");
        key(4'h2, mk(24'h120000, 2, 2'b00, 0, 0, 0, 0), "to_2");
        for (int i = 0; i < 15; i++) idle(mk(24'h120000, 2, 2'b00, 0, 0, 0, 0), "to_wait");
        idle(mk(0, 0, 2'b00, 0, 0, 0, 1), "to_expire");
        idle(mk(0, 0, 2'b00, 0, 0, 0, 0), "to_after");

        // Key on the expiry cycle wins and restarts the count
        key(4'h1, mk(24'h100000, 1, 2'b00, 0, 0, 0, 0), "tk_1");
        key(4'h2, mk(24'h120000, 2, 2'b00, 0, 0, 0, 0), "tk_2");
        for (int i = 0; i < 15; i++) idle(mk(24'h120000, 2, 2'b00, 0, 0, 0, 0), "tk_wait");
        key(4'h3, mk(24'h123000, 3, 2'b00, 0, 0, 0, 0), "tk_key_wins");
        for (int i = 0; i < 15; i++) idle(mk(24'h123000, 3, 2'b00, 0, 0, 0, 0), "tk_wait2");
        idle(mk(0, 0, 2'b00, 0, 0, 0, 1), "tk_expire");

        // Reset in the middle of the confirm stage
        unlocked = 1'b1;
        key(4'hD, mk(0, 0, 2'b01, 0, 0, 0, 0), "rs_start");
        type_code(24'h123456, 2'b01, "rs_new");
        key(4'hC, mk(0, 0, 2'b10, 0, 0, 0, 0), "rs_enter1");
        key(4'h1, mk(24'h100000, 1, 2'b10, 0, 0, 0, 0), "rs_c1");
        key(4'h2, mk(24'h120000, 2, 2'b10, 0, 0, 0, 0), "rs_c2");
        key(4'h3, mk(24'h123000, 3, 2'b10, 0, 0, 0, 0), "rs_c3");
        step(1'b1, 1'b0, 4'h0, mk(0, 0, 2'b00, 0, 0, 0, 0), "rs_reset");
        unlocked = 1'b0;
        type_code(24'h987650, 2'b00, "rs_unlock");
        key(4'hC, mk(24'h987650, 6, 2'b00, 1, 0, 0, 0), "rs_cmp");
        idle(mk(0, 0, 2'b00, 0, 0, 0, 0), "rs_clear");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
